adc_spi_capture: RTL
====================

Name: adc_spi_capture

Overview:
- Serial front end for the MIKROE-340 (MCP3201, 12-bit SPI ADC): drives cs_n and sclk, shifts in MISO, and presents a parallel 12-bit sample with a one-cycle valid strobe.
- Sits directly downstream of the 50 kHz ADC clock-divider stage.
- Generates sclk internally from clk using the same 50 MHz -> 50 kHz ratio, so all logic runs in the single clk domain.
- Result feeds the twinning comparison logic.

Parameters:
- HALF_PERIOD, 500, clk cycles per sclk half-phase (500 -> 50 kHz sclk from 50 MHz clk); legal range 3..65535.
- CS_SETUP, 500, clk cycles cs_n is held low with sclk low before the first sclk rising edge; legal range 1..65535.
- CS_IDLE, 500, minimum clk cycles cs_n is held high between conversions; legal range 1..65535.

Ports:
- clk, input, 1, 50 MHz system clock.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request a conversion; sampled only in IDLE; level-held start gives back-to-back conversions.
- miso, input, 1, ADC serial data out; asynchronous to clk.
- cs_n, output, 1, ADC chip select, active low.
- sclk, output, 1, ADC serial clock; idles low.
- data, output, 12, last completed sample, B11 = MSB.
- data_valid, output, 1, one-cycle pulse when data updates.
- null_err, output, 1, registered with data; 1 if the null bit of that frame read 1.
- busy, output, 1, high from cs_n assertion through the end of HOLD.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst). Reset has priority over all other logic.
- Reset values: cs_n=1, sclk=0, data=0, data_valid=0, null_err=0, busy=0, state=IDLE, all counters=0, shift register=0, synchronizer flops=0.
- miso input: passes through a 2-flop synchronizer before any use.
- FSM states: IDLE, SETUP, CLK_LOW, CLK_HIGH, HOLD.
- IDLE: cs_n=1, sclk=0, busy=0. If start=1 at edge T, then at T+1: state=SETUP, cs_n=0, busy=1, phase counter=0, bit counter=0.
- SETUP: cs_n=0, sclk=0 for exactly CS_SETUP cycles, then go to CLK_HIGH. Every sclk period therefore begins with the rising edge and the last period ends low.
- CLK_HIGH: sclk=1 for HALF_PERIOD cycles.
  - On the final cycle of the phase, capture the synchronized miso into the shift register (shift left, LSB in).
  - Increment the bit counter, then go to CLK_LOW.
- CLK_LOW: sclk=0 for HALF_PERIOD cycles.
  - If the bit counter is below 15, return to CLK_HIGH.
  - If the bit counter equals 15, go to HOLD.
- Frame layout: exactly 15 sclk rising edges per conversion.
  - Captures 1-2: sample period, discarded.
  - Capture 3: null bit, latched for null_err.
  - Captures 4-15: B11..B0.
- Entering HOLD (single cycle): data <= shift[11:0], null_err <= latched null bit, data_valid=1, cs_n=1.
- HOLD: cs_n=1, sclk=0, busy=1 for CS_IDLE cycles, then go to IDLE with busy=0.
  - start is re-sampled only in IDLE, so the minimum gap between conversions is CS_IDLE+1 cycles with cs_n high.
- start outside IDLE: ignored, not queued.
- Counters: phase counter 16 bits, compared against parameter-1; bit counter 4 bits, saturates at 15.
- Reset mid-conversion: next cycle cs_n=1, sclk=0, busy=0, data=0, no data_valid pulse; the partial frame is discarded.
- data and null_err hold their value until the next data_valid; data_valid is never high for two consecutive cycles.

Test Plan:
- Reset during and after power-up: rst=1 for 3 cycles with start=1 -> cs_n=1, sclk=0, busy=0, data=0, data_valid=0 throughout; first frame begins only after rst falls.
- Nominal frame (HALF_PERIOD=4, CS_SETUP=2, CS_IDLE=3): ADC model drives null=0, sample 0xA5C on sclk falling edges.
  - Required: cs_n low for 2+15*8=122 cycles.
  - Required: exactly 15 sclk pulses, each 4 high / 4 low.
  - Required: data=0xA5C, null_err=0, data_valid high for 1 cycle at the cs_n rising edge.
- Boundary values: model returns 0x000, then 0xFFF, with start held high.
  - Required: data=0x000, then 0xFFF.
  - Required: cs_n high for exactly 4 cycles between frames.
  - Required: busy low for exactly 1 cycle between frames.
- Null-bit fault: model drives null bit=1 and sample 0x123 -> data=0x123, null_err=1; next clean frame clears null_err=0.
- Reset mid-frame: assert rst after the 7th sclk rising edge -> next cycle cs_n=1, sclk=0, busy=0, data=0, no data_valid pulse; the following start produces a full 15-pulse frame.
- start pulses during SETUP, CLK_HIGH and HOLD: all ignored; exactly one frame and one data_valid per start accepted in IDLE.

Source files
------------

// File: rtl/adc_spi_capture.sv
// adc_spi_capture: SPI master front end for an MCP3201 12-bit ADC.
// Generates cs_n/sclk from clk, shifts in 15 bits per frame and presents
// the 12-bit sample with a one-cycle data_valid strobe and a null-bit flag.
module adc_spi_capture #(
  parameter int unsigned HALF_PERIOD = 500,
  parameter int unsigned CS_SETUP    = 500,
  parameter int unsigned CS_IDLE     = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        miso,
  output logic        cs_n,
  output logic        sclk,
  output logic [11:0] data,
  output logic        data_valid,
  output logic        null_err,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    CLK_LOW,
    CLK_HIGH,
    HOLD
  } state_t;

  localparam logic [15:0] HALF_LAST  = 16'(HALF_PERIOD - 1);
  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] IDLE_LAST  = 16'(CS_IDLE - 1);

  state_t      state;
  logic [15:0] phase;
  logic [3:0]  bit_cnt;
  logic [11:0] shift;
  logic        null_bit;
  logic        miso_meta;
  logic        miso_sync;

  // Two-flop synchronizer: miso comes from the ADC with no relation to clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      miso_meta <= 1'b0;
      miso_sync <= 1'b0;
    end else begin
      miso_meta <= miso;
      miso_sync <= miso_meta;
    end
  end

  // Frame sequencer: all SPI outputs and results are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      phase      <= 16'd0;
      bit_cnt    <= 4'd0;
      shift      <= 12'd0;
      null_bit   <= 1'b0;
      cs_n       <= 1'b1;
      sclk       <= 1'b0;
      data       <= 12'd0;
      data_valid <= 1'b0;
      null_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (state)
        IDLE: begin
          cs_n <= 1'b1;
          sclk <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            state   <= SETUP;
            cs_n    <= 1'b0;
            busy    <= 1'b1;
            phase   <= 16'd0;
            bit_cnt <= 4'd0;
          end
        end

        SETUP: begin
          if (phase == SETUP_LAST) begin
            state <= CLK_HIGH;
            sclk  <= 1'b1;
            phase <= 16'd0;
          end else begin
            phase <= phase + 16'd1;
          end
        end

        CLK_HIGH: begin
          if (phase == HALF_LAST) begin
            // Sample at the end of the high phase, well after the ADC
            // changed its output on the preceding falling edge.
            shift <= {shift[10:0], miso_sync};
            if (bit_cnt == 4'd2) begin
              null_bit <= miso_sync;
            end
            if (bit_cnt != 4'd15) begin
              bit_cnt <= bit_cnt + 4'd1;
            end
            sclk  <= 1'b0;
            state <= CLK_LOW;
            phase <= 16'd0;
          end else begin
            phase <= phase + 16'd1;
          end
        end

        CLK_LOW: begin
          if (phase == HALF_LAST) begin
            phase <= 16'd0;
            if (bit_cnt < 4'd15) begin
              state <= CLK_HIGH;
              sclk  <= 1'b1;
            end else begin
              // Last 12 captures are B11..B0, so the low 12 bits of the
              // shift register hold the finished sample.
              state      <= HOLD;
              data       <= shift;
              null_err   <= null_bit;
              data_valid <= 1'b1;
              cs_n       <= 1'b1;
            end
          end else begin
            phase <= phase + 16'd1;
          end
        end

        HOLD: begin
          cs_n <= 1'b1;
          sclk <= 1'b0;
          if (phase == IDLE_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
            phase <= 16'd0;
          end else begin
            phase <= phase + 16'd1;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
